// File: rtl/mode_select_ctrl.sv
// rtl/mode_select_ctrl.sv - front-panel button debounce and SELECT/ACTIVE mode controller
//
// Purpose: turns four raw push-buttons into registered mode/song codes, an
// active flag and a one-cycle start pulse for the player datapath.
// Optional feature macro: AUTO_NEXT_EN (continuous playlist in AUTO mode).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   btn_mode     raw button: next mode
//   btn_song     raw button: next song
//   btn_confirm  raw button: enter selected mode
//   btn_back     raw button: leave active mode
//   song_done    one-cycle pulse from the player when a song finishes
//   state        mode code FREE=0, AUTO=1, STDY=2, PLAY=3, SET=4
//   song         selected song code 0..NUM_SONGS-1
//   active       high while the selected mode is running
//   start_pulse  one-cycle pulse when a mode is entered or restarted
module mode_select_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int NUM_SONGS  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_song,
  input  logic       btn_confirm,
  input  logic       btn_back,
  input  logic       song_done,
  output logic [2:0] state,
  output logic [2:0] song,
  output logic       active,
  output logic       start_pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [2:0]       LAST_SONG = 3'(NUM_SONGS - 1);

  localparam logic [2:0] MODE_FREE = 3'd0;
  localparam logic [2:0] MODE_AUTO = 3'd1;
  localparam logic [2:0] MODE_STDY = 3'd2;
  localparam logic [2:0] MODE_PLAY = 3'd3;
  localparam logic [2:0] MODE_SET  = 3'd4;

  // Button index: 0 song, 1 mode, 2 confirm, 3 back.
  logic [3:0] btn_raw;
  logic [3:0] press;
  assign btn_raw = {btn_back, btn_confirm, btn_mode, btn_song};

  // Counts the first edges after reset so the synchronizers hold real
  // samples before any button may be armed.
  logic [1:0] init_q;
  logic       init_done;
  assign init_done = (init_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 2'd0;
    end else if (!init_done) begin
      init_q <= init_q + 2'd1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_dly_q;
    logic             armed_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        armed_q      <= 1'b0;
        press_q      <= 1'b0;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= btn_raw[i];
        sync2_q      <= sync1_q;
        stable_dly_q <= stable_q;
        // A button held through reset must be seen released before its
        // next rise counts as a press.
        armed_q      <= armed_q | (init_done & ~sync2_q);
        press_q      <= stable_q & ~stable_dly_q & armed_q;
        if (sync2_q != stable_q) begin
          if (cnt_q == DEB_LAST) begin
            cnt_q    <= '0;
            stable_q <= ~stable_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign press[i] = press_q;
  end

  logic press_song, press_mode, press_confirm, press_back;
  assign press_song    = press[0];
  assign press_mode    = press[1];
  assign press_confirm = press[2];
  assign press_back    = press[3];

  typedef enum logic {
    SELECT = 1'b0,
    ACTIVE = 1'b1
  } fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [2:0] state_q, state_d;
  logic [2:0] song_q, song_d;
  logic       start_q, start_d;
  logic [2:0] next_mode, next_song;

  assign next_mode = (state_q == MODE_SET)  ? MODE_FREE : state_q + 3'd1;
  assign next_song = (song_q  == LAST_SONG) ? 3'd0      : song_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= SELECT;
      state_q <= MODE_FREE;
      song_q  <= 3'd0;
      start_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      song_q  <= song_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    song_d  = song_q;
    start_d = 1'b0;
    case (fsm_q)
      SELECT: begin
        // Only the highest-priority press is acted on; a back press in
        // SELECT does nothing but still swallows the lower presses.
        if (!press_back) begin
          if (press_confirm) begin
            fsm_d   = ACTIVE;
            start_d = 1'b1;
          end else if (press_mode) begin
            state_d = next_mode;
          end else if (press_song) begin
            song_d = next_song;
          end
        end
      end
      ACTIVE: begin
        if (press_back) begin
          fsm_d = SELECT;
        end else if (song_done) begin
`ifdef AUTO_NEXT_EN
          if (state_q == MODE_AUTO) begin
            // Skipped right after a start so start_pulse never repeats
            // on consecutive cycles.
            if (!start_q) begin
              song_d  = next_song;
              start_d = 1'b1;
            end
          end else if (state_q == MODE_STDY || state_q == MODE_PLAY) begin
            fsm_d = SELECT;
          end
`else
          if (state_q == MODE_AUTO || state_q == MODE_STDY ||
              state_q == MODE_PLAY) begin
            fsm_d = SELECT;
          end
`endif
        end
      end
      default: fsm_d = SELECT;
    endcase
  end

  assign state       = state_q;
  assign song        = song_q;
  assign active      = (fsm_q == ACTIVE);
  assign start_pulse = start_q;

endmodule

// File: tb/tb_mode_select_ctrl.sv
// tb/tb_mode_select_ctrl.sv - directed self-checking bench for mode_select_ctrl
module tb_mode_select_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_song = 1'b0;
  logic       btn_confirm = 1'b0;
  logic       btn_back = 1'b0;
  logic       song_done = 1'b0;
  logic [2:0] state;
  logic [2:0] song;
  logic       active;
  logic       start_pulse;

  int checks = 0;
  int passes = 0;

  mode_select_ctrl #(.DEB_CYCLES(4), .NUM_SONGS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_song(btn_song),
    .btn_confirm(btn_confirm), .btn_back(btn_back),
    .song_done(song_done),
    .state(state), .song(song), .active(active), .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_song = v;
      1: btn_mode = v;
      2: btn_confirm = v;
      default: btn_back = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    set_btn(b, 1'b1);
    tick(12);
    set_btn(b, 1'b0);
    tick(10);
  endtask

  task automatic pulse_done();
    song_done = 1'b1;
    tick(1);
    song_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_mode = 1'b0; btn_song = 1'b0; btn_confirm = 1'b0; btn_back = 1'b0;
    song_done = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_reset();
    tick(2);
    checks++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else passes++;
    checks++; if (song !== 3'd0) $display("FAIL reset_song got %0d exp 0", song); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL reset_active got %b exp 0", active); else passes++;
    checks++; if (start_pulse !== 1'b0) $display("FAIL reset_start got %b exp 0", start_pulse); else passes++;
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_mode_latency();
    btn_mode = 1'b1;
    tick(7);
    checks++; if (state !== 3'd0) $display("FAIL latency_edge7 got %0d exp 0", state); else passes++;
    tick(1);
    checks++; if (state !== 3'd1) $display("FAIL latency_edge8 got %0d exp 1", state); else passes++;
    tick(12);
    checks++; if (state !== 3'd1) $display("FAIL held_one_step got %0d exp 1", state); else passes++;
    btn_mode = 1'b0;
    tick(10);
    press_btn(1);
    checks++; if (state !== 3'd2) $display("FAIL second_press got %0d exp 2", state); else passes++;
    press_btn(1);
    press_btn(1);
    checks++; if (state !== 3'd4) $display("FAIL mode_set got %0d exp 4", state); else passes++;
    press_btn(1);
    checks++; if (state !== 3'd0) $display("FAIL mode_wrap got %0d exp 0", state); else passes++;
  endtask

  task automatic test_glitch();
    btn_song = 1'b1;
    tick(3);
    btn_song = 1'b0;
    tick(12);
    checks++; if (song !== 3'd0) $display("FAIL glitch_song got %0d exp 0", song); else passes++;
    press_btn(0);
    checks++; if (song !== 3'd1) $display("FAIL song_press got %0d exp 1", song); else passes++;
    press_btn(0);
    checks++; if (song !== 3'd0) $display("FAIL song_wrap got %0d exp 0", song); else passes++;
  endtask

  task automatic test_play();
    do_reset();
    press_btn(1); press_btn(1); press_btn(1);
    press_btn(0);
    checks++; if (state !== 3'd3) $display("FAIL play_state got %0d exp 3", state); else passes++;
    btn_confirm = 1'b1;
    tick(7);
    checks++; if (active !== 1'b0) $display("FAIL confirm_early got %b exp 0", active); else passes++;
    tick(1);
    checks++; if (active !== 1'b1) $display("FAIL confirm_active got %b exp 1", active); else passes++;
    checks++; if (start_pulse !== 1'b1) $display("FAIL confirm_start got %b exp 1", start_pulse); else passes++;
    tick(1);
    checks++; if (start_pulse !== 1'b0) $display("FAIL start_one_cycle got %b exp 0", start_pulse); else passes++;
    tick(11);
    btn_confirm = 1'b0;
    tick(10);
    press_btn(1);
    press_btn(0);
    checks++; if (state !== 3'd3) $display("FAIL frozen_state got %0d exp 3", state); else passes++;
    checks++; if (song !== 3'd1) $display("FAIL frozen_song got %0d exp 1", song); else passes++;
    checks++; if (active !== 1'b1) $display("FAIL still_active got %b exp 1", active); else passes++;
    press_btn(3);
    checks++; if (active !== 1'b0) $display("FAIL back_active got %b exp 0", active); else passes++;
  endtask

  task automatic test_auto_done();
    do_reset();
    press_btn(1);
    press_btn(2);
    checks++; if (active !== 1'b1) $display("FAIL auto_active got %b exp 1", active); else passes++;
    pulse_done();
`ifdef AUTO_NEXT_EN
    checks++; if (active !== 1'b1) $display("FAIL auto_next_active got %b exp 1", active); else passes++;
    checks++; if (song !== 3'd1) $display("FAIL auto_next_song got %0d exp 1", song); else passes++;
    checks++; if (start_pulse !== 1'b1) $display("FAIL auto_next_start got %b exp 1", start_pulse); else passes++;
    tick(1);
    checks++; if (start_pulse !== 1'b0) $display("FAIL auto_next_start_end got %b exp 0", start_pulse); else passes++;
    tick(3);
    pulse_done();
    checks++; if (song !== 3'd0) $display("FAIL auto_next_wrap got %0d exp 0", song); else passes++;
    checks++; if (active !== 1'b1) $display("FAIL auto_next_active2 got %b exp 1", active); else passes++;
`else
    checks++; if (active !== 1'b0) $display("FAIL auto_done_active got %b exp 0", active); else passes++;
    checks++; if (song !== 3'd0) $display("FAIL auto_done_song got %0d exp 0", song); else passes++;
    checks++; if (start_pulse !== 1'b0) $display("FAIL auto_done_start got %b exp 0", start_pulse); else passes++;
    tick(3);
    pulse_done();
    checks++; if (active !== 1'b0) $display("FAIL select_done_ignored got %b exp 0", active); else passes++;
`endif
  endtask

  task automatic test_priority();
    do_reset();
    btn_confirm = 1'b1;
    btn_mode = 1'b1;
    tick(12);
    btn_confirm = 1'b0;
    btn_mode = 1'b0;
    tick(10);
    checks++; if (active !== 1'b1) $display("FAIL prio_active got %b exp 1", active); else passes++;
    checks++; if (state !== 3'd0) $display("FAIL prio_state got %0d exp 0", state); else passes++;
    pulse_done();
    tick(2);
    checks++; if (active !== 1'b1) $display("FAIL free_done_active got %b exp 1", active); else passes++;
  endtask

  task automatic test_reset_active();
    do_reset();
    press_btn(1);
    press_btn(0);
    press_btn(2);
    checks++; if (active !== 1'b1) $display("FAIL pre_reset_active got %b exp 1", active); else passes++;
    btn_back = 1'b1;
    btn_mode = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) $display("FAIL async_state got %0d exp 0", state); else passes++;
    checks++; if (song !== 3'd0) $display("FAIL async_song got %0d exp 0", song); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL async_active got %b exp 0", active); else passes++;
    checks++; if (start_pulse !== 1'b0) $display("FAIL async_start got %b exp 0", start_pulse); else passes++;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    checks++; if (state !== 3'd0) $display("FAIL held_after_reset_state got %0d exp 0", state); else passes++;
    checks++; if (active !== 1'b0) $display("FAIL held_after_reset_active got %b exp 0", active); else passes++;
    btn_back = 1'b0;
    btn_mode = 1'b0;
    tick(10);
    press_btn(1);
    checks++; if (state !== 3'd1) $display("FAIL rearmed_press got %0d exp 1", state); else passes++;
  endtask

  initial begin
    test_reset();
    test_mode_latency();
    test_glitch();
    test_play();
    test_auto_done();
    test_priority();
    test_reset_active();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mode_select_ctrl.md
Name: mode_select_ctrl

Overview:
Front-panel controller that turns four raw push-buttons into the registered mode code `state[2:0]` and song code `song[2:0]`. Those codes drive the seven-segment display stage and the player datapath. The block debounces and edge-detects each button, runs a SELECT/ACTIVE state machine, and issues a one-cycle start pulse to the player. It sits directly upstream of the display driver and beside the tone generator.

Parameters:
- DEB_CYCLES, 1000000, consecutive cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz).
- NUM_SONGS, 2, number of selectable songs; song codes are 0..NUM_SONGS-1, legal range 1..8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  raw button, active-high: next mode
- btn_song  in  1  raw button, active-high: next song
- btn_confirm  in  1  raw button, active-high: enter selected mode
- btn_back  in  1  raw button, active-high: leave active mode
- song_done  in  1  one-cycle pulse from the player when a song finishes
- state  out  3  mode code: FREE=0, AUTO=1, STDY=2, PLAY=3, SET=4
- song  out  3  selected song code: 0 = little_star, 1 = two_tigers
- active  out  1  1 while the selected mode is running
- start_pulse  out  1  one-cycle pulse when a mode is entered or restarted

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=0, song=0, active=0, start_pulse=0, FSM=SELECT; all synchronizers, debounce counters and stable levels are cleared.
- Reset asserted mid-operation aborts everything immediately. No pulse is emitted after reset releases, even if a button is held. A held button needs release then press.
- Per button, the input path is:
  - 2-FF synchronizer.
  - Debounce counter: counts the edges on which the synchronized level differs from the stable level, and clears on any edge where they match.
  - The stable level toggles on the DEB_CYCLES-th consecutive mismatch edge.
  - A registered rising-edge detector on the stable level produces a one-cycle press pulse.
- Latency: raw rise, held stable, to an FSM-driven output change = DEB_CYCLES+4 clk edges.
- A button held indefinitely yields exactly one press pulse. Glitches shorter than DEB_CYCLES cycles yield none.
- Press priority when pulses coincide: back > confirm > mode > song. Only the highest-priority press is acted on in that cycle; the others are dropped.
- FSM state SELECT (active=0):
  - mode press: state advances 0→1→2→3→4→0.
  - song press: song advances by 1, wrapping from NUM_SONGS-1 to 0. This applies in every mode; song is ignored downstream for FREE and SET.
  - confirm press: go to ACTIVE, active=1, start_pulse=1 for exactly one cycle, on the same edge.
  - back press and song_done: ignored.
- FSM state ACTIVE (active=1):
  - mode, song and confirm presses are ignored; state and song are frozen.
  - back press: go to SELECT, active=0 on that edge.
  - song_done while state ∈ {AUTO, STDY, PLAY}: go to SELECT, active=0.
  - song_done while state ∈ {FREE, SET}: ignored.
  - song_done coinciding with a back press: one transition to SELECT; no extra action.
- state and song are registered outputs and change only on clk edges. start_pulse is never high for two consecutive cycles.

Optional Feature:
- Macro: AUTO_NEXT_EN.
- Defined: song_done in ACTIVE with state=AUTO advances song by 1 with wrap, stays ACTIVE, and pulses start_pulse for one cycle on the same edge, giving continuous playlist playback. Behaviour in all other modes is unchanged.
- Undefined: song_done in AUTO returns to SELECT, as in the base behaviour.

Test Plan:
1. DEB_CYCLES=4: reset, hold btn_mode high for 20 cycles → state 0→1 exactly 8 edges after the raw rise; one step only; release then press again → state=2.
2. DEB_CYCLES=4: 3-cycle btn_song glitch → song stays 0; clean press → song=1; another press → song=0 (wrap, NUM_SONGS=2).
3. Select PLAY (3 mode presses), song=1, then confirm → active=1, start_pulse high for exactly 1 cycle; mode/song presses while active → state=3, song=1 unchanged; back → active=0.
4. AUTO active, song=0, song_done pulse → without AUTO_NEXT_EN: active=0, song=0. With AUTO_NEXT_EN: active=1, song=1, one start_pulse. Repeat the song_done → song=0 (wrap).
5. btn_confirm and btn_mode pressed on the same cycle in SELECT → confirm wins: active=1, state unchanged. In FREE active, song_done → ignored, active=1.
6. Assert rst_n low while ACTIVE with btn_back held → all outputs 0 immediately; release reset with the button still held → no press acted on, FSM in SELECT.
